// File: rtl/steer_en_fsm.sv
// Steering-enable controller: latches load-cell readings, judges rider presence and balance,
// and enables steering once the rider has stayed balanced for a full settle period.
module steer_en_fsm #(
  parameter bit          fast_sim      = 1'b0,
  parameter logic [11:0] MIN_RIDER_WT  = 12'h200,
  parameter logic [11:0] WT_HYSTERESIS = 12'h040
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_vld,
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  output logic        en_steer,
  output logic        rider_off
);

  typedef enum logic [1:0] {StIdle, StWait, StSteer} state_e;

  localparam logic [12:0] WtHigh = {1'b0, MIN_RIDER_WT} + {1'b0, WT_HYSTERESIS};
  localparam logic [12:0] WtLow  = {1'b0, MIN_RIDER_WT} - {1'b0, WT_HYSTERESIS};

  state_e      state_q, state_d;
  logic [25:0] tmr_q, tmr_d;
  logic [11:0] lft_q, rght_q;
  logic [12:0] sum;
  logic [11:0] diff;
  logic        sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16, tmr_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_q  <= '0;
      rght_q <= '0;
    end else if (ld_vld) begin
      lft_q  <= lft_ld;
      rght_q <= rght_ld;
    end
  end

  always_comb begin
    sum           = {1'b0, lft_q} + {1'b0, rght_q};
    diff          = (lft_q >= rght_q) ? (lft_q - rght_q) : (rght_q - lft_q);
    sum_gt_min    = sum > WtHigh;
    sum_lt_min    = sum < WtLow;
    diff_gt_1_4   = {1'b0, diff} > (sum >> 2);
    diff_gt_15_16 = {1'b0, diff} > (sum - (sum >> 4));
    tmr_full      = fast_sim ? (&tmr_q[14:0]) : (&tmr_q);
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    unique case (state_q)
      StIdle: begin
        if (sum_gt_min) begin
          state_d = StWait;
          tmr_d   = '0;
        end
      end
      StWait: begin
        if (sum_lt_min) begin
          state_d = StIdle;
        end else if (diff_gt_1_4) begin
          tmr_d = '0;
        end else if (tmr_full) begin
          state_d = StSteer;
        end else begin
          tmr_d = tmr_q + 26'd1;
        end
      end
      StSteer: begin
        if (sum_lt_min) begin
          state_d = StIdle;
        end else if (diff_gt_15_16) begin
          state_d = StWait;
          tmr_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered copies of the state decode so they cannot glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      tmr_q     <= '0;
      en_steer  <= 1'b0;
      rider_off <= 1'b1;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      en_steer  <= (state_d == StSteer);
      rider_off <= (state_d == StIdle);
    end
  end

endmodule

// File: tb/tb_steer_en_fsm.sv
// Bench for steer_en_fsm: two instances share stimulus (separate resets) and are compared
// every cycle against a behavioural model, plus directed literal checks.
module tb_steer_en_fsm;

  localparam int Settle = 1 << 15;
  localparam int WtHigh = 'h200 + 'h040;
  localparam int WtLow  = 'h200 - 'h040;

  localparam logic [1:0] MIdle = 2'd0, MWait = 2'd1, MSteer = 2'd2;

  typedef struct packed {
    logic [11:0] lft;
    logic [11:0] rght;
    logic [1:0]  st;
    logic [15:0] cnt;
  } mdl_t;

  logic        clk = 1'b0;
  logic        rst_n0 = 1'b1;
  logic        rst_n1 = 1'b1;
  logic        ld_vld;
  logic [11:0] lft, rght;
  logic        en0, ro0, en1, ro1;
  mdl_t        m0, m1;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  steer_en_fsm #(.fast_sim(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n0), .ld_vld(ld_vld), .lft_ld(lft), .rght_ld(rght),
    .en_steer(en0), .rider_off(ro0)
  );

  steer_en_fsm #(.fast_sim(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n1), .ld_vld(ld_vld), .lft_ld(lft), .rght_ld(rght),
    .en_steer(en1), .rider_off(ro1)
  );

  // One clock of rider behaviour expressed directly from the weight/balance rules.
  function automatic mdl_t step(mdl_t c, logic v, logic [11:0] l, logic [11:0] r);
    mdl_t n;
    int   a, b, sum, diff;
    bit   heavy, light, lean, tip;
    n     = c;
    a     = int'(c.lft);
    b     = int'(c.rght);
    sum   = a + b;
    diff  = (a > b) ? a - b : b - a;
    heavy = sum > WtHigh;
    light = sum < WtLow;
    lean  = diff > sum / 4;
    tip   = diff > sum - sum / 16;
    case (c.st)
      MIdle: if (heavy) begin n.st = MWait; n.cnt = '0; end
      MWait: begin
        if (light) n.st = MIdle;
        else if (lean) n.cnt = '0;
        else if (int'(c.cnt) == Settle - 1) n.st = MSteer;
        else n.cnt = c.cnt + 16'd1;
      end
      default: begin
        if (light) n.st = MIdle;
        else if (tip) begin n.st = MWait; n.cnt = '0; end
      end
    endcase
    if (v) begin
      n.lft  = l;
      n.rght = r;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n0) begin
    if (!rst_n0) m0 <= '0;
    else m0 <= step(m0, ld_vld, lft, rght);
  end

  always @(posedge clk or negedge rst_n1) begin
    if (!rst_n1) m1 <= '0;
    else m1 <= step(m1, ld_vld, lft, rght);
  end

  task automatic check(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check("u0_en_vs_model", en0, m0.st == MSteer);
    check("u0_off_vs_model", ro0, m0.st == MIdle);
    check("u1_en_vs_model", en1, m1.st == MSteer);
    check("u1_off_vs_model", ro1, m1.st == MIdle);
  endtask

  task automatic load(input logic [11:0] l, input logic [11:0] r);
    ld_vld = 1'b1;
    lft    = l;
    rght   = r;
    tick();
    ld_vld = 1'b0;
  endtask

  function automatic logic [11:0] pick();
    if ($urandom_range(0, 3) == 0) return 12'($urandom_range(0, 4095));
    return 12'($urandom_range('h0C0, 'h170));
  endfunction

  initial begin
    ld_vld = 1'b0;
    lft    = '0;
    rght   = '0;
    #1 rst_n0 = 1'b0;
    rst_n1 = 1'b0;
    #1;
    check("reset_off", ro0, 1'b1);
    check("reset_en", en0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n0 = 1'b1;
    rst_n1 = 1'b1;

    repeat (1000) tick();
    check("idle_1000_off", ro0, 1'b1);
    check("idle_1000_en", en0, 1'b0);

    load(12'h150, 12'h150);
    tick();
    check("wait_entry_off", ro0, 1'b0);
    check("wait_entry_en", en0, 1'b0);
    repeat (2000) tick();
    check("wait_midway_en", en0, 1'b0);

    // Unbalanced sample restarts the settle period.
    load(12'h200, 12'h080);
    load(12'h150, 12'h150);
    repeat (Settle - 1) tick();
    check("settle_early_en", en0, 1'b0);
    tick();
    check("settle_done_en", en0, 1'b1);
    check("settle_done_off", ro0, 1'b0);
    check("settle_done_u1", en1, 1'b1);

    // Short asynchronous reset on u1 only, between clock edges.
    #1 rst_n1 = 1'b0;
    #1;
    check("async_rst_en", en1, 1'b0);
    check("async_rst_off", ro1, 1'b1);
    check("async_rst_u0_kept", en0, 1'b1);
    #2 rst_n1 = 1'b1;

    load(12'h108, 12'h0F8);
    repeat (3) tick();
    check("steer_small_diff", en0, 1'b1);
    check("u1_stays_idle", ro1, 1'b1);
    load(12'h0F8, 12'h0F8);
    repeat (3) tick();
    check("steer_in_band", en0, 1'b1);
    load(12'h0D8, 12'h0D8);
    tick();
    check("steer_light_off", ro0, 1'b1);
    check("steer_light_en", en0, 1'b0);

    load(12'h150, 12'h150);
    tick();
    check("rewait_u0", ro0, 1'b0);
    check("rewait_u1", ro1, 1'b0);
    repeat (Settle - 1) tick();
    check("resettle_early_u1", en1, 1'b0);
    tick();
    check("resettle_u0", en0, 1'b1);
    check("resettle_u1", en1, 1'b1);

    load(12'h300, 12'h010);
    tick();
    check("steer_tip_en", en0, 1'b0);
    check("steer_tip_off", ro0, 1'b0);

    repeat (3000) begin
      ld_vld = ($urandom_range(0, 3) == 0);
      lft    = pick();
      rght   = pick();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
